key_range_dispatcher: RTL and testbench



---
 rtl/ksa_pkg.sv | 22 ++
 rtl/krd_prio_pick.sv | 28 ++
 rtl/key_range_dispatcher.sv | 190 +++++++++++++++++++
 tb/tb_key_range_dispatcher.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ksa_pkg.sv
// Shared types and constants for the RC4 key search: dispatcher FSM states,
// key type, default search limit and the legal key character range used by
// the cracking cores.
package ksa_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    RUN    = 3'd2,
    FOUND  = 3'd3,
    FAILED = 3'd4
  } krd_state_t;

  typedef logic [23:0] rc4_key_t;

  localparam rc4_key_t KEY_MAX_DEFAULT = 24'h3FFFFF;

  // Printable lowercase range accepted by the cores when decrypting.
  localparam logic [7:0] CHAR_MIN = 8'h61;
  localparam logic [7:0] CHAR_MAX = 8'h7A;

endpackage

// File: rtl/krd_prio_pick.sv
// Lowest-index select over the masked found bits; returns whether any core
// found a key, which core won and that core's key.
module krd_prio_pick #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned KEY_W     = 24,
  parameter int unsigned IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic [NUM_CORES-1:0]       i_found,
  input  logic [NUM_CORES*KEY_W-1:0] i_keys,
  output logic                       o_any,
  output logic [IDX_W-1:0]           o_idx,
  output logic [KEY_W-1:0]           o_key
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    o_any = |i_found;
    o_idx = '0;
    o_key = '0;
    for (int c = NUM_CORES - 1; c >= 0; c--) begin
      if (i_found[c]) begin
        o_idx = IDX_W'(c);
        o_key = i_keys[c*KEY_W +: KEY_W];
      end
    end
  end

endmodule

// File: rtl/key_range_dispatcher.sv
// Splits the key space into NUM_CORES equal slices, launches one cracking core
// per slice, latches the first (lowest-index) found key and stops all cores.
// Optional watchdog: define KRD_WATCHDOG_EN to build the run-length limit.
module key_range_dispatcher
  import ksa_pkg::*;
#(
  parameter int unsigned         NUM_CORES = 4,
  parameter int unsigned         KEY_W     = 24,
  parameter logic [KEY_W-1:0]    KEY_MAX   = KEY_W'(KEY_MAX_DEFAULT),
  parameter logic [31:0]         WD_CYCLES = 32'hFFFF_FFFF
) (
  input  logic                       CLOCK_50,
  input  logic                       reset_n,
  input  logic                       go,
  output logic [NUM_CORES-1:0]       core_start,
  output logic [NUM_CORES*KEY_W-1:0] core_key_lo,
  output logic [NUM_CORES*KEY_W-1:0] core_key_hi,
  output logic                       core_stop,
  input  logic [NUM_CORES-1:0]       core_done,
  input  logic [NUM_CORES-1:0]       core_found,
  input  logic [NUM_CORES*KEY_W-1:0] core_key,
  output logic                       busy,
  output logic                       success,
  output logic                       failed,
  output logic                       timeout,
  output logic [KEY_W-1:0]           result_key
);

  localparam int unsigned SLICE = (32'(KEY_MAX) + 32'd1) / NUM_CORES;
  localparam int unsigned IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  krd_state_t             r_state;
  krd_state_t             w_state_next;
  logic [NUM_CORES-1:0]   r_done_mask;

  logic [NUM_CORES-1:0]   w_new_done;
  logic [NUM_CORES-1:0]   w_new_found;
  logic [NUM_CORES-1:0]   w_mask_next;
  logic                   w_pick_any;
  logic [IDX_W-1:0]       w_pick_idx_unused;
  logic [KEY_W-1:0]       w_pick_key;
  logic                   w_wd_hit;

  logic [NUM_CORES-1:0]   w_core_start_d;
  logic [NUM_CORES-1:0]   w_done_mask_d;
  logic                   w_busy_d;
  logic                   w_success_d;
  logic                   w_failed_d;
  logic                   w_timeout_d;
  logic                   w_core_stop_d;
  logic [KEY_W-1:0]       w_result_key_d;

  // Only reports from cores not yet recorded this run are considered.
  assign w_new_done  = core_done & ~r_done_mask;
  assign w_new_found = w_new_done & core_found;
  assign w_mask_next = r_done_mask | w_new_done;

  krd_prio_pick #(
    .NUM_CORES (NUM_CORES),
    .KEY_W     (KEY_W),
    .IDX_W     (IDX_W)
  ) u_prio_pick (
    .i_found (w_new_found),
    .i_keys  (core_key),
    .o_any   (w_pick_any),
    .o_idx   (w_pick_idx_unused),
    .o_key   (w_pick_key)
  );

`ifdef KRD_WATCHDOG_EN
  logic [31:0] r_wd_cnt;

  // Run-length counter: cleared while launching, counts every RUN cycle.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      r_wd_cnt <= '0;
    end else if (r_state == LAUNCH) begin
      r_wd_cnt <= '0;
    end else if (r_state == RUN) begin
      r_wd_cnt <= r_wd_cnt + 32'd1;
    end
  end

  assign w_wd_hit = (r_state == RUN) && (r_wd_cnt == (WD_CYCLES - 32'd1));
`else
  logic w_wd_unused;
  assign w_wd_unused = ^WD_CYCLES;
  assign w_wd_hit    = 1'b0;
`endif

  // Slice bounds are constants, registered so the core inputs come from flops.
  always_ff @(posedge CLOCK_50) begin
    for (int unsigned c = 0; c < NUM_CORES; c++) begin
      core_key_lo[c*KEY_W +: KEY_W] <= KEY_W'(c * SLICE);
      core_key_hi[c*KEY_W +: KEY_W] <= KEY_W'(c * SLICE + SLICE - 32'd1);
    end
  end

  // State register.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; a find always beats exhaustion and the watchdog.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, FOUND, FAILED: begin
        if (go) w_state_next = LAUNCH;
      end
      LAUNCH: w_state_next = RUN;
      RUN: begin
        if (w_pick_any)        w_state_next = FOUND;
        else if (w_wd_hit)     w_state_next = FAILED;
        else if (&w_mask_next) w_state_next = FAILED;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs and the done mask.
  always_comb begin
    w_core_start_d = '0;
    w_done_mask_d  = r_done_mask;
    w_busy_d       = (w_state_next == LAUNCH) || (w_state_next == RUN);
    w_success_d    = success;
    w_failed_d     = failed;
    w_timeout_d    = timeout;
    w_core_stop_d  = core_stop;
    w_result_key_d = result_key;
    case (r_state)
      IDLE, FOUND, FAILED: begin
        if (r_state == IDLE) w_core_stop_d = 1'b0;
        if (go) begin
          w_core_start_d = '1;
          w_done_mask_d  = '0;
          w_success_d    = 1'b0;
          w_failed_d     = 1'b0;
          w_timeout_d    = 1'b0;
          w_core_stop_d  = 1'b0;
          w_result_key_d = '0;
        end
      end
      RUN: begin
        w_done_mask_d = w_mask_next;
        if (w_pick_any) begin
          w_result_key_d = w_pick_key;
          w_success_d    = 1'b1;
          w_core_stop_d  = 1'b1;
        end else if (w_wd_hit) begin
          w_failed_d    = 1'b1;
          w_timeout_d   = 1'b1;
          w_core_stop_d = 1'b1;
        end else if (&w_mask_next) begin
          w_failed_d    = 1'b1;
          w_core_stop_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output registers; core_stop is held high during reset to abort the cores.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      core_start  <= '0;
      r_done_mask <= '0;
      busy        <= 1'b0;
      success     <= 1'b0;
      failed      <= 1'b0;
      timeout     <= 1'b0;
      core_stop   <= 1'b1;
      result_key  <= '0;
    end else begin
      core_start  <= w_core_start_d;
      r_done_mask <= w_done_mask_d;
      busy        <= w_busy_d;
      success     <= w_success_d;
      failed      <= w_failed_d;
      timeout     <= w_timeout_d;
      core_stop   <= w_core_stop_d;
      result_key  <= w_result_key_d;
    end
  end

endmodule

// File: tb/tb_key_range_dispatcher.sv
// Self-checking bench for key_range_dispatcher. Each scenario describes when
// every core first reports (and whether it found a key), plus an optional
// later re-report that must be ignored; the expected outcome is derived from
// those report times directly.
module tb_key_range_dispatcher;

  localparam int unsigned NC = 4;
  localparam int unsigned KW = 24;

  logic              CLOCK_50 = 1'b0;
  logic              reset_n;
  logic              go;
  logic [NC-1:0]     core_start;
  logic [NC*KW-1:0]  core_key_lo;
  logic [NC*KW-1:0]  core_key_hi;
  logic              core_stop;
  logic [NC-1:0]     core_done;
  logic [NC-1:0]     core_found;
  logic [NC*KW-1:0]  core_key;
  logic              busy;
  logic              success;
  logic              failed;
  logic              timeout;
  logic [KW-1:0]     result_key;

  int checks = 0;
  int errors = 0;

  // Scenario description: first report cycle (-1 = never), found flag, key,
  // re-report cycle (-1 = none) carrying found=1 and a junk key.
  int            sc_d  [NC];
  bit            sc_f  [NC];
  logic [KW-1:0] sc_k  [NC];
  int            sc_r  [NC];
  logic [KW-1:0] sc_rk [NC];

  key_range_dispatcher #(
    .NUM_CORES (NC),
    .KEY_W     (KW),
    .KEY_MAX   (24'h3FFFFF),
    .WD_CYCLES (32'd100)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .reset_n     (reset_n),
    .go          (go),
    .core_start  (core_start),
    .core_key_lo (core_key_lo),
    .core_key_hi (core_key_hi),
    .core_stop   (core_stop),
    .core_done   (core_done),
    .core_found  (core_found),
    .core_key    (core_key),
    .busy        (busy),
    .success     (success),
    .failed      (failed),
    .timeout     (timeout),
    .result_key  (result_key)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_sc();
    for (int c = 0; c < NC; c++) begin
      sc_d[c] = -1; sc_f[c] = 1'b0; sc_k[c] = '0; sc_r[c] = -1; sc_rk[c] = '0;
    end
  endtask

  task automatic clear_inputs();
    core_done  = '0;
    core_found = '0;
    core_key   = '0;
  endtask

  // Pulse go and check the one-cycle start pulse; returns in RUN cycle 0.
  task automatic launch(input string name);
    @(negedge CLOCK_50);
    go = 1'b1;
    @(posedge CLOCK_50); #1;
    chk({name, ".start"}, 64'(core_start), 64'(4'hF));
    chk({name, ".busy_launch"}, 64'(busy), 64'd1);
    @(negedge CLOCK_50);
    go = 1'b0;
    @(posedge CLOCK_50); #1;
    chk({name, ".start_off"}, 64'(core_start), 64'd0);
  endtask

  task automatic run_scenario(input string name);
    int tf, win, tlast, t_end;
    logic [3:0] st_exp;
    tf = 1 << 20; win = -1; tlast = -1;
    for (int c = 0; c < NC; c++) begin
      if (sc_d[c] > tlast) tlast = sc_d[c];
      if (sc_d[c] >= 0 && sc_f[c] && sc_d[c] < tf) begin
        tf = sc_d[c]; win = c;
      end
    end
    t_end = (win >= 0) ? tf : tlast;
    launch(name);
    for (int cyc = 0; cyc <= t_end; cyc++) begin
      @(negedge CLOCK_50);
      clear_inputs();
      for (int c = 0; c < NC; c++) begin
        if (cyc == sc_d[c]) begin
          core_done[c] = 1'b1; core_found[c] = sc_f[c]; core_key[c*KW +: KW] = sc_k[c];
        end else if (cyc == sc_r[c]) begin
          core_done[c] = 1'b1; core_found[c] = 1'b1; core_key[c*KW +: KW] = sc_rk[c];
        end
      end
      @(posedge CLOCK_50); #1;
      // status = {busy, success, failed, core_stop}
      if (cyc != t_end)    st_exp = 4'b1000;
      else if (win >= 0)   st_exp = 4'b0101;
      else                 st_exp = 4'b0011;
      if (cyc == t_end || st_exp !== {busy, success, failed, core_stop})
        chk($sformatf("%s.status@%0d", name, cyc), 64'({busy, success, failed, core_stop}), 64'(st_exp));
    end
    chk({name, ".result_key"}, 64'(result_key), 64'((win >= 0) ? sc_k[win] : 24'h0));
    chk({name, ".timeout"}, 64'(timeout), 64'd0);
    @(negedge CLOCK_50);
    clear_inputs();
  endtask

  initial begin
    logic [KW-1:0] slice;
    reset_n = 1'b0;
    go      = 1'b0;
    clear_inputs();
    clear_sc();

    // Reset values
    @(posedge CLOCK_50); @(posedge CLOCK_50); #1;
    chk("rst.stop", 64'(core_stop), 64'd1);
    chk("rst.outs", 64'({core_start, busy, success, failed, timeout, result_key}), 64'd0);
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    @(posedge CLOCK_50); #1;
    chk("idle.stop", 64'(core_stop), 64'd0);

    // Slice bounds: each slice is a quarter of the 22-bit space
    slice = 24'(32'h400000 / NC);
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("bound.lo%0d", c), 64'(core_key_lo[c*KW +: KW]), 64'(24'(c) * slice));
      chk($sformatf("bound.hi%0d", c), 64'(core_key_hi[c*KW +: KW]), 64'(24'(c) * slice + slice - 24'd1));
    end

    // Single find on core 2
    clear_sc();
    sc_d[2] = 5; sc_f[2] = 1'b1; sc_k[2] = 24'h2A1B3C;
    run_scenario("single");

    // Simultaneous finds on cores 1 and 3: lowest index wins
    clear_sc();
    sc_d[1] = 7; sc_f[1] = 1'b1; sc_k[1] = 24'h123456;
    sc_d[3] = 7; sc_f[3] = 1'b1; sc_k[3] = 24'h3ABCDE;
    run_scenario("simul");

    // Exhaustion with core 0 reporting again (re-report must be ignored)
    clear_sc();
    sc_d[0] = 10; sc_d[1] = 10; sc_d[2] = 25; sc_d[3] = 40;
    sc_r[0] = 18; sc_rk[0] = 24'h0BADBA;
    run_scenario("exhaust");

    // Find in the same cycle the mask would complete: find wins
    clear_sc();
    sc_d[0] = 3; sc_d[1] = 3; sc_d[2] = 8; sc_d[3] = 8;
    sc_f[3] = 1'b1; sc_k[3] = 24'h35AA55;
    run_scenario("found_vs_full");

    // Randomized scenarios
    for (int n = 0; n < 12; n++) begin
      clear_sc();
      for (int c = 0; c < NC; c++) begin
        sc_d[c]  = int'($urandom_range(0, 30));
        sc_f[c]  = ($urandom_range(0, 3) == 0);
        sc_k[c]  = 24'($urandom());
        sc_r[c]  = ($urandom_range(0, 1) == 1) ? sc_d[c] + int'($urandom_range(1, 8)) : -1;
        sc_rk[c] = 24'($urandom());
      end
      run_scenario($sformatf("rand%0d", n));
    end

    // Reset in the middle of RUN
    launch("rstrun");
    repeat (20) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    reset_n = 1'b0;
    @(posedge CLOCK_50); #1;
    chk("rstrun.stop", 64'(core_stop), 64'd1);
    chk("rstrun.outs", 64'({core_start, busy, success, failed, timeout, result_key}), 64'd0);
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    @(posedge CLOCK_50); #1;
    chk("rstrun.idle", 64'({core_stop, core_start, busy, success, failed, timeout, result_key}), 64'd0);
    chk("rstrun.bound", 64'(core_key_hi[3*KW +: KW]), 64'(24'h3FFFFF));
    clear_sc();
    sc_d[0] = 2; sc_f[0] = 1'b1; sc_k[0] = 24'h0F00D1;
    run_scenario("relaunch");

`ifdef KRD_WATCHDOG_EN
    // Watchdog: no reports, failure visible 100 cycles after RUN entry
    launch("wd");
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(posedge CLOCK_50); #1;
      if (cyc == 99 || {busy, failed} !== 2'b10)
        chk($sformatf("wd.status@%0d", cyc), 64'({busy, success, failed, core_stop}),
            64'((cyc == 99) ? 4'b0011 : 4'b1000));
    end
    chk("wd.timeout", 64'(timeout), 64'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #2_000_000;
    $display("FAIL timeout_guard observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule
